// File: rtl/demux1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel delivered-word counters are enabled by defining DEMUX1X4_CNT_EN.
module demux1x4_stream #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [4*W-1:0]   out_data
`ifdef DEMUX1X4_CNT_EN
  ,
  output logic [4*CNT_W-1:0] out_cnt
`endif
);

  logic [3:0]   valid_q, valid_d;
  logic [W-1:0] data_q [4];
  logic [W-1:0] data_d [4];
  logic [3:0]   load, drain;

  // A full channel still accepts when it drains on the same edge.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];

  always_comb begin
    load    = '0;
    drain   = valid_q & out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned i = 0; i < 4; i++) begin
      load[i] = in_valid & in_ready & (in_sel == 2'(i));
      if (load[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_data;
      end else if (drain[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < 4; i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid = valid_q;

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < 4; i++) out_data[i*W +: W] = data_q[i];
  end

`ifdef DEMUX1X4_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        if (drain[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    out_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) out_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed self-checking bench for demux1x4_stream; counter checks need DEMUX1X4_CNT_EN.
module tb_demux1x4_stream;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*W-1:0] out_data;
`ifdef DEMUX1X4_CNT_EN
  logic [4*CNT_W-1:0] out_cnt;
`endif

  demux1x4_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX1X4_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // out_data expectations are {ch3,ch2,ch1,ch0}
    vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000};
    vecs[1]  = '{1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0001, 32'h00A50010};
    vecs[2]  = '{1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 32'h00A51110};
    vecs[3]  = '{1'b1, 2'd2, 8'h12, 4'b1111, 1'b1, 4'b0100, 32'h00121110};
    vecs[4]  = '{1'b1, 2'd3, 8'h13, 4'b1111, 1'b1, 4'b1000, 32'h13121110};
    vecs[5]  = '{1'b0, 2'd3, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h13121110};
    vecs[6]  = '{1'b1, 2'd1, 8'h21, 4'b1101, 1'b1, 4'b0010, 32'h13122110};
    vecs[7]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 32'h13122110};
    vecs[8]  = '{1'b1, 2'd3, 8'h31, 4'b1101, 1'b1, 4'b1010, 32'h31122110};
    vecs[9]  = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h31122210};
    vecs[10] = '{1'b1, 2'd0, 8'h30, 4'b0000, 1'b1, 4'b0011, 32'h31122230};
    vecs[11] = '{1'b1, 2'd0, 8'h33, 4'b0001, 1'b1, 4'b0011, 32'h31122233};
    vecs[12] = '{1'b1, 2'd0, 8'h44, 4'b0000, 1'b0, 4'b0011, 32'h31122233};
    vecs[13] = '{1'b1, 2'd2, 8'h52, 4'b0000, 1'b1, 4'b0111, 32'h31522233};
    vecs[14] = '{1'b1, 2'd3, 8'h53, 4'b0000, 1'b1, 4'b1111, 32'h53522233};
    vecs[15] = '{1'b1, 2'd1, 8'h99, 4'b0000, 1'b0, 4'b1111, 32'h53522233};

    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 8'hFF;
    out_ready = 4'b0000;
    #1 rst_n  = 1'b0;
    #1;
    chk("reset_ov", 32'(out_valid), 32'h0);
    chk("reset_od", out_data, 32'h0);
    chk("reset_rdy", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("reset_edge_ov", 32'(out_valid), 32'h0);
    chk("reset_edge_od", out_data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      in_valid  = vecs[i].vld;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d_od", i), out_data, vecs[i].exp_od);
    end

    // Async reset pulse with all four channels full
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", 32'(out_valid), 32'h0);
    chk("midrst_od", out_data, 32'h0);
`ifdef DEMUX1X4_CNT_EN
    chk("midrst_cnt", 32'(out_cnt), 32'h0);
`endif
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("midrst_rdy_sel%0d", s), 32'(in_ready), 32'h1);
    end
    in_sel = 2'd1;
    @(posedge clk); #1;
    chk("midrst_edge_ov", 32'(out_valid), 32'h0);
    rst_n    = 1'b1;
    in_data  = 8'h77;
    #1;
    chk("release_rdy", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("release_ov", 32'(out_valid), 32'h2);
    chk("release_od", out_data, 32'h00007700);

    // 17 words streamed through ch3 with ch1 stalled
    out_ready = 4'b1000;
    for (int k = 1; k <= 17; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 8'(k);
      #1;
      chk($sformatf("ch3_k%0d_rdy", k), 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("ch3_k%0d_od", k), 32'(out_data[31:24]), 32'(k));
`ifdef DEMUX1X4_CNT_EN
      if (k == 17) chk("cnt_wrap0", 32'(out_cnt), 32'h0);
`endif
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ch3_drained_ov", 32'(out_valid), 32'h2);
    chk("ch1_held_od", 32'(out_data[15:8]), 32'h77);
`ifdef DEMUX1X4_CNT_EN
    chk("cnt_final", 32'(out_cnt), 32'h1000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
